// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/LUI, serial SLL/SRL shifting SHIFT_STEP bits per cycle.
// start/busy/done handshake; starts arriving while shifting are dropped, not queued.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_Start,
  input  logic [3:0]            in_ALUOperation_4,
  input  logic [DATA_WIDTH-1:0] in_A_32,
  input  logic [DATA_WIDTH-1:0] in_B_32,
  input  logic [4:0]            in_Shamt_5,
  output logic [DATA_WIDTH-1:0] o_ALUResult_32,
  output logic                  o_Zero,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int HALF = DATA_WIDTH / 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] result, imm_result, shreg, shreg_nxt;
  logic [4:0]            cnt, cnt_nxt, step;
  logic                  shift_left;
  logic                  accept, is_shift;

  always_comb begin
    imm_result = '0;
    case (in_ALUOperation_4)
      OP_AND:         imm_result = in_A_32 & in_B_32;
      OP_OR:          imm_result = in_A_32 | in_B_32;
      OP_NOR:         imm_result = ~(in_A_32 | in_B_32);
      OP_ADD:         imm_result = in_A_32 + in_B_32;
      OP_SUB:         imm_result = in_A_32 - in_B_32;
      // Only reached here with shamt == 0, so the shift is the identity.
      OP_SLL, OP_SRL: imm_result = in_B_32;
      OP_LUI:         imm_result = {in_B_32[HALF-1:0], {HALF{1'b0}}};
      default:        imm_result = '0;
    endcase
  end

  assign is_shift = ((in_ALUOperation_4 == OP_SLL) || (in_ALUOperation_4 == OP_SRL)) &&
                    (in_Shamt_5 != 5'd0);

  // Final step may be shorter than SHIFT_STEP so the total equals shamt exactly.
  always_comb begin
    step = 5'(SHIFT_STEP);
    if (int'(cnt) < SHIFT_STEP) step = cnt;
  end

  assign shreg_nxt = shift_left ? (shreg << step) : (shreg >> step);
  assign cnt_nxt   = cnt - step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_Busy    = 1'b0;
    o_Done    = 1'b0;
    case (state)
      IDLE, DONE: begin
        o_Done = (state == DONE);
        accept = in_Start;
        if (in_Start) state_nxt = is_shift ? SHIFT : DONE;
        else          state_nxt = IDLE;
      end
      SHIFT: begin
        o_Busy = 1'b1;
        if (cnt_nxt == 5'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result     <= '0;
      shreg      <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        shreg      <= in_B_32;
        cnt        <= in_Shamt_5;
        shift_left <= (in_ALUOperation_4 == OP_SLL);
      end else begin
        result <= imm_result;
      end
    end else if (state == SHIFT) begin
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      if (cnt_nxt == 5'd0) result <= shreg_nxt;
    end
  end

  assign o_ALUResult_32 = result;
  assign o_Zero         = (result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases plus random traffic, scoreboard fed by the driver
// and drained by an independent monitor on o_Done.
module tb_alu_multicycle;

  localparam int DW   = 32;
  localparam int STEP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_start;
  logic [3:0]    in_op;
  logic [DW-1:0] in_a, in_b;
  logic [4:0]    in_sh;
  logic [DW-1:0] o_res;
  logic          o_zero, o_busy, o_done;

  alu_multicycle #(.DATA_WIDTH(DW), .SHIFT_STEP(STEP)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_Start          (in_start),
    .in_ALUOperation_4 (in_op),
    .in_A_32           (in_a),
    .in_B_32           (in_b),
    .in_Shamt_5        (in_sh),
    .o_ALUResult_32    (o_res),
    .o_Zero            (o_zero),
    .o_Busy            (o_busy),
    .o_Done            (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    int            done_cyc;
    int            busy;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            free_cyc = 0;
  logic [DW-1:0] last_res = '0;
  int            busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input int sh);
    logic [DW-1:0] lo;
    lo = b & ((DW'(1) << (DW/2)) - 1);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~(a | b);
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return (sh >= DW) ? '0 : (b << sh);
      4'd6:    return (sh >= DW) ? '0 : (b >> sh);
      4'd7:    return lo << (DW/2);
      default: return '0;
    endcase
  endfunction

  // Drive one cycle of inputs; if the model says the DUT can accept, queue the expectation.
  task automatic drive(input bit st, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] sh);
    int lat;
    exp_t e;
    @(posedge clk); #1;
    in_start = st; in_op = op; in_a = a; in_b = b; in_sh = sh;
    if (st && reset && cyc >= free_cyc) begin
      lat = 1;
      if ((op == 4'd5 || op == 4'd6) && sh != 5'd0) lat = 1 + (int'(sh) + STEP - 1) / STEP;
      e.res      = ref_alu(op, a, b, int'(sh));
      e.done_cyc = cyc + lat;
      e.busy     = lat - 1;
      q.push_back(e);
      free_cyc   = cyc + lat;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, '0, '0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_result"}, 64'(o_res), 64'd0);
    check({tag, "_zero"},   64'(o_zero), 64'd1);
    check({tag, "_busy"},   64'(o_busy), 64'd0);
    check({tag, "_done"},   64'(o_done), 64'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        busy_cnt = 0;
        last_res = '0;
      end else begin
        if (o_busy) busy_cnt++;
        if (o_done) begin
          if (q.size() == 0) begin
            check("spurious_done", 64'(o_done), 64'd0);
          end else begin
            e = q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("result", 64'(o_res), 64'(e.res));
            check("zero", 64'(o_zero), 64'(e.res == '0));
            check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
            last_res = e.res;
          end
          busy_cnt = 0;
        end else begin
          check("result_hold", 64'(o_res), 64'(last_res));
          check("zero_hold", 64'(o_zero), 64'(last_res == '0));
        end
        if (q.size() > 0 && cyc > q[0].done_cyc) begin
          check("missing_done", 64'(0), 64'(1));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    logic [4:0]    sh;
    bit            st;

    reset = 1'b0; in_start = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_sh = '0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    free_cyc = cyc;

    // ADD 5+7, then AND issued in the DONE cycle (back-to-back accept)
    drive(1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    drive(1'b1, 4'd0, 32'hFF, 32'h0F, 5'd0);
    idle(2);
    // SUB to zero, LUI
    drive(1'b1, 4'd4, 32'd9, 32'd9, 5'd0);
    idle(1);
    drive(1'b1, 4'd7, 32'd0, 32'h0000_1234, 5'd0);
    idle(2);
    // Long SLL with ADD starts hammered mid-shift (must be ignored)
    drive(1'b1, 4'd5, 32'd0, 32'd1, 5'd31);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd3, 32'd1, 32'd2, 5'd0);
    idle(12);
    // SRL with a short final step
    drive(1'b1, 4'd6, 32'd0, 32'hF000_0000, 5'd4);
    idle(4);
    // NOP codes, SLL with shamt 0
    drive(1'b1, 4'd9, 32'd3, 32'd4, 5'd0);
    drive(1'b1, 4'd5, 32'd0, 32'hABCD, 5'd0);
    idle(2);
    // Reset in the middle of a shift, then a normal op
    drive(1'b1, 4'd5, 32'd0, 32'd1, 5'd31);
    idle(3);
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midshift_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    free_cyc = cyc;
    drive(1'b1, 4'd3, 32'd100, 32'd23, 5'd0);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 9) < 6);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : DW'($urandom);
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      drive(st, op, a, b, sh);
    end

    idle(40);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
